// File: rtl/shift_right_iterative.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV), STEP bits per clock, start/busy/done handshake.
// Define SHIFT_RIGHT_EARLY_DONE_EN to finish as soon as the operand has collapsed to its fill pattern.
module shift_right_iterative #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
        $error("shift_right_iterative: STEP must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] StepAmt = 5'(STEP);

    typedef enum logic {StIdle, StShift} state_e;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] out_q, out_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        arith_q, arith_d;
    logic        done_q, done_d;

    logic [4:0]  k;
    logic [31:0] shifted;
    logic        finish;

    always_comb begin
        // The last step may be shorter than STEP when shamt is not a multiple of it.
        k       = (cnt_q > StepAmt) ? StepAmt : cnt_q;
        shifted = arith_q ? $unsigned($signed(data_q) >>> k) : (data_q >> k);
`ifdef SHIFT_RIGHT_EARLY_DONE_EN
        finish  = (cnt_q == 5'd0) || (data_q == {32{arith_q & data_q[31]}});
`else
        finish  = (cnt_q == 5'd0);
`endif
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        arith_d = arith_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = in_data;
                    cnt_d   = shamt;
                    arith_d = arith;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (finish) begin
                    out_d   = data_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    data_d = shifted;
                    cnt_d  = cnt_q - k;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= 32'h0;
            out_q   <= 32'h0;
            cnt_q   <= 5'd0;
            arith_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            arith_q <= arith_d;
            done_q  <= done_d;
        end
    end

    assign out_data = out_q;
    assign busy     = (state_q == StShift);
    assign done     = done_q;

endmodule

// File: tb/tb_shift_right_iterative.sv
// Bench for shift_right_iterative: STEP=1 and STEP=4 instances driven in parallel,
// directed vector table, hand-written corner sequences and randomized operations.
module tb_shift_right_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in_data;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] out1, out4;
    logic        busy1, busy4, done1, done4;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    shift_right_iterative #(.STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .shamt(shamt),
        .arith(arith), .out_data(out1), .busy(busy1), .done(done1)
    );

    shift_right_iterative #(.STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .shamt(shamt),
        .arith(arith), .out_data(out4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp_r;
        int          lat1;
        int          lat4;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // Reference: result is a plain shift of the whole operand.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
        if (a) return $unsigned($signed(d) >>> s);
        return d >> s;
    endfunction

    function automatic int ref_lat(input logic [31:0] d, input int s, input logic a,
                                   input int step);
        int n;
        n = (s + step - 1) / step;
`ifdef SHIFT_RIGHT_EARLY_DONE_EN
        for (int i = 0; i < n; i++) begin
            logic [31:0] v;
            v = ref_shift(d, i * step, a);
            if (v == ((a && v[31]) ? 32'hFFFF_FFFF : 32'h0)) return i + 1;
        end
`endif
        return n + 1;
    endfunction

    // Launch one operation and collect completion of both instances.
    // ign_at > 0 re-asserts start with other operands that many cycles after acceptance.
    task automatic op(input logic [31:0] d, input logic [4:0] s, input logic a, input int ign_at,
                      output int lat1, output int lat4, output int bcnt, output int dcnt,
                      output logic [31:0] r1, output logic [31:0] r4);
        @(negedge clk);
        in_data = d; shamt = s; arith = a; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat1 = -1; lat4 = -1; r1 = 'x; r4 = 'x; dcnt = 0;
        bcnt = busy1 ? 1 : 0;
        check("done_low_after_accept", {30'h0, done1, done4}, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            if (c == ign_at) begin
                in_data = ~d; shamt = 5'd1; arith = ~a; start = 1'b1;
            end
            if (c == ign_at + 1) start = 1'b0;
            @(posedge clk);
            #1;
            if (done1) dcnt++;
            if (done1 && lat1 < 0) begin lat1 = c; r1 = out1; end
            if (done4 && lat4 < 0) begin lat4 = c; r4 = out4; end
            if (busy1 && lat1 < 0) bcnt++;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic [31:0] d, input logic [4:0] s,
                               input logic a, input int ign_at, input logic [31:0] exp_r,
                               input int exp1, input int exp4);
        int l1, l4, bc, dc;
        logic [31:0] r1, r4;
        op(d, s, a, ign_at, l1, l4, bc, dc, r1, r4);
        check({tag, "_res1"}, r1, exp_r);
        check({tag, "_res4"}, r4, exp_r);
        check({tag, "_lat1"}, 32'(l1), 32'(exp1));
        check({tag, "_lat4"}, 32'(l4), 32'(exp4));
        check({tag, "_busy1"}, 32'(bc), 32'(exp1));
        check({tag, "_done_once"}, 32'(dc), 32'd1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 5,  2};
        vecs[1] = '{32'hF000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, 9};
        vecs[2] = '{32'hF000_0000, 5'd31, 1'b0, 32'h0000_0001, 32, 9};
        vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1,  1};
        vecs[4] = '{32'h1234_5678, 5'd8,  1'b0, 32'h0012_3456, 9,  3};
        vecs[5] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32, 9};
        vecs[6] = '{32'h0000_0001, 5'd20, 1'b0, 32'h0000_0000, 21, 6};
        vecs[7] = '{32'h7FFF_FFFF, 5'd1,  1'b1, 32'h3FFF_FFFF, 2,  2};
        vecs[8] = '{32'h8000_0001, 5'd3,  1'b1, 32'hF000_0000, 4,  2};

        rst_n = 1'b0; start = 1'b0; in_data = '0; shamt = '0; arith = 1'b0;
        #3;
        check("reset_out1", out1, 32'h0);
        check("reset_flags", {28'h0, busy1, done1, busy4, done4}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table; each op is launched in the previous op's done cycle.
        for (int i = 0; i < 9; i++) begin
            int e1, e4;
`ifdef SHIFT_RIGHT_EARLY_DONE_EN
            e1 = ref_lat(vecs[i].d, int'(vecs[i].s), vecs[i].a, 1);
            e4 = ref_lat(vecs[i].d, int'(vecs[i].s), vecs[i].a, 4);
`else
            e1 = vecs[i].lat1;
            e4 = vecs[i].lat4;
`endif
            run_checked($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].a, 0,
                        vecs[i].exp_r, e1, e4);
        end

        // Start while busy must be ignored.
        run_checked("ignore", 32'hAAAA_5555, 5'd16, 1'b0, 3, 32'h0000_AAAA,
                    ref_lat(32'hAAAA_5555, 16, 1'b0, 1), ref_lat(32'hAAAA_5555, 16, 1'b0, 4));

        // Reset mid-operation aborts with no completion.
        begin
            int dseen;
            @(negedge clk);
            in_data = 32'hFFFF_0000; shamt = 5'd16; arith = 1'b1; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("abort_out1", out1, 32'h0);
            check("abort_out4", out4, 32'h0);
            check("abort_flags", {28'h0, busy1, done1, busy4, done4}, 32'h0);
            dseen = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (done1 || done4 || busy1 || busy4) dseen++;
            end
            check("abort_quiet", 32'(dseen), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("abort_idle", {30'h0, done1, busy1}, 32'h0);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic        a;
            case ($urandom_range(0, 3))
                0: d = 32'($urandom_range(0, 15));
                1: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            run_checked($sformatf("rnd%0d", i), d, s, a, (i % 5 == 0) ? 2 : 0,
                        ref_shift(d, int'(s), a), ref_lat(d, int'(s), a, 1),
                        ref_lat(d, int'(s), a, 4));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
